// File: rtl/nrzi_rx_pkg.sv
// Shared USB receive definitions: line states, receiver FSM states,
// protocol constants and packet-size constants.
package nrzi_rx_pkg;

   // Encoding matches the raw {dp, dm} pair so a sample casts directly.
   typedef enum logic [1:0] {
      SE0 = 2'b00,
      K   = 2'b01,
      J   = 2'b10,
      SE1 = 2'b11
   } line_state_t;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_SYNC  = 3'd1,
      RX_DATA  = 3'd2,
      RX_EOP   = 3'd3,
      RX_ABORT = 3'd4
   } rx_state_t;

   // Decoded 0s that must precede the terminating 1 of SYNC.
   localparam int unsigned SYNC_ZEROS = 7;
   // Consecutive decoded 1s after which a stuffed 0 is expected.
   localparam int unsigned STUFF_RUN  = 6;
   // SE0 bit times that make up a valid EOP.
   localparam int unsigned EOP_SE0    = 2;

   // Packet sizes in bytes, PID included.
   localparam int unsigned TOK_S       = 3;
   localparam int unsigned DATA_S      = 1027;
   localparam int unsigned HANDSHAKE_S = 1;

   function automatic logic is_jk(input line_state_t s);
      return (s == J) || (s == K);
   endfunction

endpackage

// File: rtl/nrzi_rx_unstuff.sv
// Bit de-stuffing: tracks the run of decoded 1s, drops the stuffed 0,
// flags a stuffing violation and counts removed bits per packet.
module nrzi_rx_unstuff #(
   parameter int unsigned STUFF_RUN = 6
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       clear,
   input  logic       en,
   input  logic       dec_bit,
   output logic       emit,
   output logic       stuff_err,
   output logic [5:0] stuffed_cnt
);

   localparam int unsigned OW = $clog2(STUFF_RUN + 1);
   localparam logic [OW-1:0] RUN = OW'(STUFF_RUN);

   logic [OW-1:0] ones_cnt;
   logic          at_run;
   logic          drop;

   // Classify the current decoded bit as payload, stuffed bit or violation.
   always_comb begin
      at_run    = (ones_cnt == RUN);
      emit      = en && !at_run;
      drop      = en && at_run && !dec_bit;
      stuff_err = en && at_run && dec_bit;
   end

   // Run-length counter and saturating stuffed-bit counter.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ones_cnt    <= '0;
         stuffed_cnt <= '0;
      end else if (clear) begin
         ones_cnt    <= '0;
         stuffed_cnt <= '0;
      end else if (en) begin
         if (at_run)
            ones_cnt <= '0;
         else if (dec_bit)
            ones_cnt <= ones_cnt + 1'b1;
         else
            ones_cnt <= '0;
         if (drop && (stuffed_cnt != '1))
            stuffed_cnt <= stuffed_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/nrzi_rx.sv
// USB NRZI receiver: classifies dp/dm samples, locks on SYNC, decodes and
// de-stuffs the payload, detects EOP and reports stuffing/EOP errors.
module nrzi_rx
   import nrzi_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst_b,
   input  logic       dp_in,
   input  logic       dm_in,
   output logic       bstr_out,
   output logic       bstr_out_valid,
   output logic       rx_active,
   output logic       pkt_end,
   output logic       stuff_err,
   output logic       eop_err,
   output logic [5:0] stuffed_out
);

   localparam int unsigned ZW = $clog2(SYNC_ZEROS + 2);
   localparam int unsigned SW = $clog2(EOP_SE0 + 1);
   localparam logic [ZW-1:0] SYNC_ZEROS_C = ZW'(SYNC_ZEROS);
   localparam logic [SW-1:0] EOP_SE0_C    = SW'(EOP_SE0);

   line_state_t   line_q, prev_q;
   rx_state_t     state, state_d;
   logic [ZW-1:0] zero_cnt, zero_d;
   logic [SW-1:0] se0_cnt, se0_d;
   logic          abt_se0, abt_d;
   logic          dec_bit;
   logic          line_jk;
   logic          lock;
   logic          pkt_d, eop_d, act_d;
   logic          ust_en, ust_emit, ust_err;

   assign line_jk = is_jk(line_q);
   assign dec_bit = (line_q == prev_q);
   assign ust_en  = (state == RX_DATA) && line_jk;

   nrzi_rx_unstuff #(
      .STUFF_RUN (STUFF_RUN)
   ) u_unstuff (
      .clk         (clk),
      .rst_b       (rst_b),
      .clear       (lock),
      .en          (ust_en),
      .dec_bit     (dec_bit),
      .emit        (ust_emit),
      .stuff_err   (ust_err),
      .stuffed_cnt (stuffed_out)
   );

   // Receiver FSM next-state and pulse decisions for the registered sample.
   always_comb begin
      state_d = state;
      zero_d  = zero_cnt;
      se0_d   = se0_cnt;
      abt_d   = abt_se0;
      lock    = 1'b0;
      pkt_d   = 1'b0;
      eop_d   = 1'b0;
      act_d   = rx_active;
      case (state)
         RX_IDLE: begin
            if (line_q == K) begin
               state_d = RX_SYNC;
               zero_d  = ZW'(1);
            end
         end
         RX_SYNC: begin
            if (!line_jk) begin
               state_d = RX_IDLE;
            end else if (!dec_bit) begin
               if (zero_cnt != '1)
                  zero_d = zero_cnt + 1'b1;
            end else if (zero_cnt == SYNC_ZEROS_C) begin
               state_d = RX_DATA;
               lock    = 1'b1;
               act_d   = 1'b1;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_DATA: begin
            case (line_q)
               J, K: begin
                  if (ust_err) begin
                     state_d = RX_ABORT;
                     act_d   = 1'b0;
                     abt_d   = 1'b0;
                  end
               end
               SE0: begin
                  state_d = RX_EOP;
                  se0_d   = SW'(1);
               end
               SE1: begin
                  eop_d   = 1'b1;
                  state_d = RX_ABORT;
                  act_d   = 1'b0;
                  abt_d   = 1'b0;
               end
            endcase
         end
         RX_EOP: begin
            if ((line_q == J) && (se0_cnt == EOP_SE0_C)) begin
               pkt_d   = 1'b1;
               act_d   = 1'b0;
               state_d = RX_IDLE;
            end else if ((line_q == SE0) && (se0_cnt != EOP_SE0_C)) begin
               se0_d = se0_cnt + 1'b1;
            end else begin
               eop_d   = 1'b1;
               act_d   = 1'b0;
               abt_d   = 1'b0;
               state_d = RX_ABORT;
            end
         end
         RX_ABORT: begin
            if (line_q == SE0)
               abt_d = 1'b1;
            else if ((line_q == J) && abt_se0)
               state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // Input register, J/K history, FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         line_q         <= J;
         prev_q         <= J;
         state          <= RX_IDLE;
         zero_cnt       <= '0;
         se0_cnt        <= '0;
         abt_se0        <= 1'b0;
         bstr_out       <= 1'b0;
         bstr_out_valid <= 1'b0;
         rx_active      <= 1'b0;
         pkt_end        <= 1'b0;
         stuff_err      <= 1'b0;
         eop_err        <= 1'b0;
      end else begin
         line_q <= line_state_t'({dp_in, dm_in});
         if (line_jk)
            prev_q <= line_q;
         state          <= state_d;
         zero_cnt       <= zero_d;
         se0_cnt        <= se0_d;
         abt_se0        <= abt_d;
         bstr_out       <= ust_emit && dec_bit;
         bstr_out_valid <= ust_emit;
         rx_active      <= act_d;
         pkt_end        <= pkt_d;
         stuff_err      <= ust_err;
         eop_err        <= eop_d;
      end
   end

endmodule
